// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl_pkg
//  Description : Shared core definitions: ALU and branch operation codes,
//                machine-mode trap cause codes and the trap controller
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package trap_ctrl_pkg;

    // ALU operation select
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    // Branch comparison select
    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LT  = 3'd4,
        BR_GE  = 3'd5,
        BR_LTU = 3'd6,
        BR_GEU = 3'd7
    } br_op_e;

    // mcause exception codes (low bits); bit XLEN-1 marks an interrupt
    localparam logic [4:0] c_cause_illegal     = 5'd2;
    localparam logic [4:0] c_cause_ld_misalign = 5'd4;
    localparam logic [4:0] c_cause_st_misalign = 5'd6;
    localparam logic [4:0] c_cause_m_timer     = 5'd7;
    localparam logic [4:0] c_cause_m_ext       = 5'd11;

    // Trap controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_ENTER  = 2'd2,
        ST_RETURN = 2'd3
    } trap_state_e;

endpackage : trap_ctrl_pkg
`default_nettype wire

// File: rtl/trap_cause_enc.sv
`default_nettype none
// ============================================================================
//  Module      : trap_cause_enc
//  Description : Combinational priority encoder for machine-mode traps.
//                Priority: external int > timer int > illegal > load
//                misaligned > store misaligned.
//  Ports       : i_* event flags, CSR interrupt state, instruction and
//                memory address; o_is_trap/o_is_intr flags, o_cause, o_tval.
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_cause_enc
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit SUPPORT_INTR = 1'b1
) (
    input  logic            i_illegal_instr,
    input  logic            i_ld_misalign,
    input  logic            i_st_misalign,
    input  logic            i_mstatus_mie,
    input  logic            i_mie_mtie,
    input  logic            i_mie_meie,
    input  logic            i_mip_mtip,
    input  logic            i_mip_meip,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_mem_addr,
    output logic            o_is_trap,
    output logic            o_is_intr,
    output logic [XLEN-1:0] o_cause,
    output logic [XLEN-1:0] o_tval
);

    logic       w_ext_pend;
    logic       w_tim_pend;
    logic [4:0] w_code;

    generate
        if (SUPPORT_INTR) begin : g_intr
            assign w_ext_pend = i_mstatus_mie & i_mie_meie & i_mip_meip;
            assign w_tim_pend = i_mstatus_mie & i_mie_mtie & i_mip_mtip;
        end else begin : g_no_intr
            assign w_ext_pend = 1'b0;
            assign w_tim_pend = 1'b0;
        end
    endgenerate

    always_comb begin
        o_is_trap = 1'b1;
        o_is_intr = 1'b0;
        w_code    = 5'd0;
        o_tval    = '0;
        if (w_ext_pend) begin
            o_is_intr = 1'b1;
            w_code    = c_cause_m_ext;
        end else if (w_tim_pend) begin
            o_is_intr = 1'b1;
            w_code    = c_cause_m_timer;
        end else if (i_illegal_instr) begin
            w_code    = c_cause_illegal;
            o_tval    = i_instr;
        end else if (i_ld_misalign) begin
            w_code    = c_cause_ld_misalign;
            o_tval    = i_mem_addr;
        end else if (i_st_misalign) begin
            w_code    = c_cause_st_misalign;
            o_tval    = i_mem_addr;
        end else begin
            o_is_trap = 1'b0;
        end
    end

    assign o_cause = {o_is_intr, {(XLEN-6){1'b0}}, w_code};

endmodule : trap_cause_enc
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl
//  Description : Machine-mode trap/return sequencer. Detects traps and mret
//                at the trap-check point, drains outstanding memory traffic,
//                then redirects fetch to mtvec (trap) or mepc (mret) and
//                strobes the CSR-file update.
//  Ports       : clk, rst_b (sync active-low); i_valid/i_pc/i_instr and
//                decoder flags; i_mem_addr/i_mem_busy; CSR interrupt state,
//                i_mtvec, i_mepc; o_flush, o_redirect, o_redirect_pc,
//                o_trap_take with o_mepc/o_mcause/o_mtval, o_mret_take.
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter bit SUPPORT_INTR = 1'b1,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_instr,
    input  logic            i_illegal_instr,
    input  logic            i_mret,
    input  logic            i_ld_misalign,
    input  logic            i_st_misalign,
    input  logic [XLEN-1:0] i_mem_addr,
    input  logic            i_mem_busy,
    input  logic            i_mstatus_mie,
    input  logic            i_mie_mtie,
    input  logic            i_mie_meie,
    input  logic            i_mip_mtip,
    input  logic            i_mip_meip,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    output logic            o_flush,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_trap_take,
    output logic [XLEN-1:0] o_mepc,
    output logic [XLEN-1:0] o_mcause,
    output logic [XLEN-1:0] o_mtval,
    output logic            o_mret_take
);

    trap_state_e     r_state;
    trap_state_e     w_next_state;
    logic            w_enc_trap;
    logic            w_enc_intr;
    logic [XLEN-1:0] w_enc_cause;
    logic [XLEN-1:0] w_enc_tval;
    logic            w_detect_trap;
    logic            w_detect_mret;
    logic            w_vectored;
    logic [XLEN-1:0] w_trap_target;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;

    trap_cause_enc #(
        .XLEN         (XLEN),
        .SUPPORT_INTR (SUPPORT_INTR)
    ) u_cause_enc (
        .i_illegal_instr (i_illegal_instr),
        .i_ld_misalign   (i_ld_misalign),
        .i_st_misalign   (i_st_misalign),
        .i_mstatus_mie   (i_mstatus_mie),
        .i_mie_mtie      (i_mie_mtie),
        .i_mie_meie      (i_mie_meie),
        .i_mip_mtip      (i_mip_mtip),
        .i_mip_meip      (i_mip_meip),
        .i_instr         (i_instr),
        .i_mem_addr      (i_mem_addr),
        .o_is_trap       (w_enc_trap),
        .o_is_intr       (w_enc_intr),
        .o_cause         (w_enc_cause),
        .o_tval          (w_enc_tval)
    );

    // Only the first IDLE cycle with a valid instruction can start a sequence;
    // a trap of any kind outranks a simultaneous mret.
    assign w_detect_trap = (r_state == ST_IDLE) && i_valid && w_enc_trap;
    assign w_detect_mret = (r_state == ST_IDLE) && i_valid && i_mret && !w_enc_trap;

    // Vectored mode applies to interrupts only; the latched mcause MSB is the
    // interrupt flag, so no separate register is needed for it.
    assign w_vectored    = (i_mtvec[1:0] == 2'b01) && r_mcause[XLEN-1];
    assign w_trap_target = {i_mtvec[XLEN-1:2], 2'b00}
                         + (w_vectored ? XLEN'({r_mcause[4:0], 2'b00}) : '0);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state  <= ST_IDLE;
            r_mepc   <= '0;
            r_mcause <= '0;
            r_mtval  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_detect_trap) begin
                r_mepc   <= i_pc;
                r_mcause <= w_enc_cause;
                r_mtval  <= w_enc_tval;
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        o_flush       = 1'b0;
        o_redirect    = 1'b0;
        o_redirect_pc = '0;
        o_trap_take   = 1'b0;
        o_mret_take   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_detect_trap) begin
                    o_flush      = 1'b1;
                    w_next_state = ST_DRAIN;
                end else if (w_detect_mret) begin
                    o_flush      = 1'b1;
                    w_next_state = ST_RETURN;
                end
            end
            ST_DRAIN: begin
                o_flush = 1'b1;
                if (!i_mem_busy) begin
                    w_next_state = ST_ENTER;
                end
            end
            ST_ENTER: begin
                o_flush       = 1'b1;
                o_trap_take   = 1'b1;
                o_redirect    = 1'b1;
                o_redirect_pc = w_trap_target;
                w_next_state  = ST_IDLE;
            end
            ST_RETURN: begin
                o_flush       = 1'b1;
                o_mret_take   = 1'b1;
                o_redirect    = 1'b1;
                o_redirect_pc = i_mepc;
                w_next_state  = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        // Reset is sampled at the coming edge; suppress every strobe now so a
        // sequence cut short by reset never half-commits a CSR update.
        if (!rst_b) begin
            w_next_state  = ST_IDLE;
            o_flush       = 1'b0;
            o_redirect    = 1'b0;
            o_redirect_pc = '0;
            o_trap_take   = 1'b0;
            o_mret_take   = 1'b0;
        end
    end

    assign o_mepc   = r_mepc;
    assign o_mcause = r_mcause;
    assign o_mtval  = r_mtval;

endmodule : trap_ctrl
`default_nettype wire
